// File: rtl/track_sequencer.sv
// Step sequencer that records tick-strobed notes into an external track memory and plays them back.
// Define TRACK_SEQUENCER_LOOP_EN to make playback wrap to the first step until stopped.
module track_sequencer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  input  logic          tick,
  input  logic [DW-1:0] note_in,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_we,
  output logic          mem_cs,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [DW-1:0] note_out,
  output logic          note_valid,
  output logic [1:0]    state,
  output logic [AW:0]   length
);

`ifdef TRACK_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    BAD    = 2'd3
  } state_t;

  state_t        cur;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [2:0]    rd_v;
  logic          last_step;

  assign state     = cur;
  assign last_step = ({1'b0, rptr} == (length - 1'b1));

  // Memory stays selected while a read is still travelling through the 2-clock latency.
  assign mem_cs = (cur == RECORD) || (cur == PLAY) || (|rd_v);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      length     <= '0;
      mem_waddr  <= '0;
      mem_raddr  <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      note_out   <= '0;
      note_valid <= 1'b0;
      rd_v       <= '0;
    end else begin
      mem_we     <= 1'b0;
      rd_v       <= {rd_v[1:0], 1'b0};
      note_valid <= rd_v[2];
      if (rd_v[2]) note_out <= mem_dout;

      case (cur)
        IDLE: begin
          if (rec_start) begin
            cur    <= RECORD;
            wptr   <= '0;
            length <= '0;
          end else if (play_start && (length != '0)) begin
            cur  <= PLAY;
            rptr <= '0;
          end
        end

        RECORD: begin
          if (stop) begin
            cur <= IDLE;
          end else if (tick) begin
            mem_we    <= 1'b1;
            mem_waddr <= wptr;
            mem_din   <= note_in;
            wptr      <= wptr + 1'b1;
            length    <= length + 1'b1;
            if (wptr == LAST_ADDR) cur <= IDLE;
          end
        end

        PLAY: begin
          // Stop discards every read still in flight so no late strobe escapes.
          if (stop) begin
            cur  <= IDLE;
            rd_v <= '0;
          end else if (tick) begin
            mem_raddr <= rptr;
            rd_v      <= {rd_v[1:0], 1'b1};
            if (last_step) begin
              rptr <= '0;
              if (!LOOP) cur <= IDLE;
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end

        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
// Self-checking bench for track_sequencer: a queue-based reference model, a 2-clock-latency
// track memory and directed record/play scenarios with hand-computed expectations.
module tb_track_sequencer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 8;

`ifdef TRACK_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic          tick;
  logic [DW-1:0] note_in;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic          mem_we;
  logic          mem_cs;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] note_out;
  logic          note_valid;
  logic [1:0]    state;
  logic [AW:0]   length;

  track_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .tick(tick), .note_in(note_in), .mem_waddr(mem_waddr),
    .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_cs(mem_cs), .mem_din(mem_din),
    .mem_dout(mem_dout), .note_out(note_out), .note_valid(note_valid),
    .state(state), .length(length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Track memory: address sampled one clock after it is presented, data one clock later.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] ram_q;
  always @(posedge clock) begin
    if (mem_cs && mem_we) ram[mem_waddr] <= mem_din;
    ram_q    <= ram[mem_raddr];
    mem_dout <= ram_q;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: notes are scheduled for delivery three edges after the tick edge.
  int cyc = 0;
  int m_state, m_len, m_wp, m_rp;
  int track [DEPTH];
  int pend_due [$];
  int pend_dat [$];
  int e_we, e_waddr, e_din, e_nv, e_note, e_rd, e_raddr;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_len = 0; m_wp = 0; m_rp = 0;
      pend_due.delete(); pend_dat.delete();
      e_we = 0; e_waddr = 0; e_din = 0; e_nv = 0; e_note = 0; e_rd = 0; e_raddr = 0;
    end else begin
      cyc++;
      e_we = 0; e_rd = 0; e_nv = 0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        e_nv   = 1;
        e_note = pend_dat[0];
        void'(pend_due.pop_front());
        void'(pend_dat.pop_front());
      end
      case (m_state)
        0: begin
          if (rec_start) begin
            m_state = 1; m_wp = 0; m_len = 0;
          end else if (play_start && m_len != 0) begin
            m_state = 2; m_rp = 0;
          end
        end
        1: begin
          if (stop) m_state = 0;
          else if (tick) begin
            e_we = 1; e_waddr = m_wp; e_din = note_in;
            track[m_wp] = note_in;
            m_wp++; m_len++;
            if (m_len == DEPTH) m_state = 0;
          end
        end
        default: begin
          if (stop) begin
            m_state = 0;
            pend_due.delete(); pend_dat.delete();
          end else if (tick) begin
            e_rd = 1; e_raddr = m_rp;
            pend_due.push_back(cyc + 3);
            pend_dat.push_back(track[m_rp]);
            if (m_rp == m_len - 1) begin
              m_rp = 0;
              if (!LOOP) m_state = 0;
            end else m_rp++;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("state", state, m_state);
      checkOutput("length", length, m_len);
      checkOutput("mem_we", mem_we, e_we);
      if (e_we) begin
        checkOutput("mem_waddr", mem_waddr, e_waddr);
        checkOutput("mem_din", mem_din, e_din);
      end
      if (e_rd) checkOutput("mem_raddr", mem_raddr, e_raddr);
      checkOutput("mem_cs", mem_cs, (m_state != 0 || pend_due.size() != 0) ? 1 : 0);
      checkOutput("note_valid", note_valid, e_nv);
      if (e_nv) checkOutput("note_out", note_out, e_note);
    end
  end

  // Logs of observed writes and strobes for the directed checks.
  int wlog_addr [$];
  int wlog_dat [$];
  int nv_dat [$];
  int nv_cyc [$];
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_we) begin
        wlog_addr.push_back(mem_waddr);
        wlog_dat.push_back(mem_din);
      end
      if (note_valid) begin
        nv_dat.push_back(note_out);
        nv_cyc.push_back(cyc);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic p, input logic s, input logic t,
                               input logic [DW-1:0] n);
    @(negedge clock);
    rec_start = r; play_start = p; stop = s; tick = t; note_in = n;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 8'h00);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_length"}, length, 0);
    checkOutput({tag, "_we"}, mem_we, 0);
    checkOutput({tag, "_cs"}, mem_cs, 0);
    checkOutput({tag, "_nv"}, note_valid, 0);
    checkOutput({tag, "_note"}, note_out, 0);
    checkOutput({tag, "_waddr"}, mem_waddr, 0);
    checkOutput({tag, "_raddr"}, mem_raddr, 0);
    checkOutput({tag, "_din"}, mem_din, 0);
  endtask

  int t_cyc [4];
  int nv_before;

  initial begin
    rec_start = 0; play_start = 0; stop = 0; tick = 0; note_in = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1 checkAllZero("reset");
    reset_n = 1'b1;

    // Record three notes; the tick alongside rec_start must not write.
    applyStimulus(1, 0, 0, 1, 8'h99);
    idle(1);
    applyStimulus(0, 0, 0, 1, 8'h11); idle(1);
    applyStimulus(0, 0, 0, 1, 8'h22); idle(1);
    applyStimulus(0, 0, 0, 1, 8'h33); idle(1);
    applyStimulus(0, 0, 1, 0, 8'h00);
    idle(2);
    #1;
    checkOutput("rec3_count", wlog_addr.size(), 3);
    if (wlog_addr.size() == 3) begin
      checkOutput("rec3_a0", wlog_addr[0], 0); checkOutput("rec3_d0", wlog_dat[0], 8'h11);
      checkOutput("rec3_a1", wlog_addr[1], 1); checkOutput("rec3_d1", wlog_dat[1], 8'h22);
      checkOutput("rec3_a2", wlog_addr[2], 2); checkOutput("rec3_d2", wlog_dat[2], 8'h33);
    end
    checkOutput("rec3_length", length, 3);
    checkOutput("rec3_state", state, 0);

    // Play with four ticks five clocks apart.
    nv_dat.delete(); nv_cyc.delete();
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 8'h00);
      t_cyc[k] = cyc + 1;
      idle(1);
      if (k == 2) #1 checkOutput("play_state_after3", state, LOOP ? 2 : 0);
      idle(3);
    end
    idle(1);
    #1;
    checkOutput("play_strobes", nv_dat.size(), LOOP ? 4 : 3);
    if (nv_dat.size() >= 3) begin
      checkOutput("play_n0", nv_dat[0], 8'h11);
      checkOutput("play_n1", nv_dat[1], 8'h22);
      checkOutput("play_n2", nv_dat[2], 8'h33);
      for (int k = 0; k < 3; k++) checkOutput("play_latency", nv_cyc[k] - t_cyc[k], 3);
    end
    if (LOOP && nv_dat.size() == 4) checkOutput("play_wrap_n3", nv_dat[3], 8'h11);
    if (LOOP) applyStimulus(0, 0, 1, 0, 8'h00);
    idle(3);

    // Back-to-back ticks keep their order and each get a strobe.
    nv_dat.delete(); nv_cyc.delete();
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(1);
    repeat (3) applyStimulus(0, 0, 0, 1, 8'h00);
    idle(5);
    if (LOOP) applyStimulus(0, 0, 1, 0, 8'h00);
    idle(2);
    #1;
    checkOutput("b2b_strobes", nv_dat.size(), 3);
    if (nv_dat.size() == 3) begin
      checkOutput("b2b_n0", nv_dat[0], 8'h11);
      checkOutput("b2b_n2", nv_dat[2], 8'h33);
      checkOutput("b2b_spacing", nv_cyc[2] - nv_cyc[0], 2);
    end

    // Stop together with a tick discards the in-flight read and issues none.
    nv_before = nv_dat.size();
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(1);
    applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 1, 1, 8'h00);
    idle(6);
    #1;
    checkOutput("stop_no_strobe", nv_dat.size() - nv_before, 0);
    checkOutput("stop_state", state, 0);

    // rec_start wins over play_start; empty track then refuses to play.
    applyStimulus(1, 1, 0, 0, 8'h00);
    idle(1);
    #1 checkOutput("recwins_state", state, 1);
    applyStimulus(0, 0, 1, 0, 8'h00);
    idle(1);
    #1 checkOutput("empty_length", length, 0);
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(2);
    #1 checkOutput("empty_play_state", state, 0);

    // Fill the whole track; the 65th tick lands in IDLE and writes nothing.
    wlog_addr.delete(); wlog_dat.delete();
    applyStimulus(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 0, 1, 8'(i ^ 8'hA5));
    idle(2);
    #1;
    checkOutput("full_writes", wlog_addr.size(), DEPTH);
    if (wlog_addr.size() == DEPTH) begin
      checkOutput("full_last_addr", wlog_addr[DEPTH-1], DEPTH - 1);
      checkOutput("full_last_dat", wlog_dat[DEPTH-1], (DEPTH - 1) ^ 8'hA5);
    end
    checkOutput("full_length", length, DEPTH);
    checkOutput("full_state", state, 0);

    // Reset during playback with reads in flight.
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(1);
    applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h00);
    idle(1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 checkAllZero("midreset");
    nv_before = nv_dat.size();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(6);
    #1;
    checkOutput("midreset_no_strobe", nv_dat.size() - nv_before, 0);
    applyStimulus(0, 1, 0, 0, 8'h00);
    idle(2);
    #1 checkOutput("midreset_play_ignored", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
